ifetch_queue: RTL

Parametrised instruction-fetch front end: owns the PC, issues one word-aligned read per cycle to a synchronous 1-cycle-latency instruction ROM, and buffers returned instructions with their PC in a small fetch queue. The decode stage drains the queue over a valid/ready handshake. Branch, jal and jalr targets are resolved downstream and arrive as a single redirect. The block flushes queued and in-flight fetches and restarts at the target.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch front end.
//   INSTR_W       instruction word width
//   NOP_INSTR     addi x0,x0,0; presented on out_instr while the queue is empty
//   MAX_ADDR_W    widest supported PC; narrower PCs are zero-extended into entries
//   fetch_entry_t one fetch-queue entry: instruction word plus the PC it came from
//   fq_ptr_w()    pointer width for a queue of the given (power-of-two) depth
package ifetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int MAX_ADDR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [MAX_ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with first-word fall-through read.
//   clk    system clock
//   rst    synchronous active-low reset (empties the FIFO)
//   push   write din at the tail this cycle
//   pop    consume the head this cycle
//   flush  discard all contents (wins over push/pop)
//   din    write data
//   dout   head entry, read combinationally from storage
//   count  occupied entries (0..DEPTH)
//   empty  count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = fq_ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage is never reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

  // The owner is expected to never overfill or over-drain the FIFO.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      if (push && !pop) assert (count_reg != CNT_W'(DEPTH));
      if (pop) assert (count_reg != '0);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end. Owns the PC, issues one word read
// per cycle to a 1-cycle-latency ROM and buffers {instr, pc} in a fetch queue
// drained by decode over valid/ready. A redirect flushes everything and
// restarts fetch at the (word-aligned) target.
//   clk             system clock
//   rst             synchronous active-low reset
//   imem_req        ROM read enable this cycle
//   imem_addr       ROM byte address (current pc)
//   imem_rdata      ROM data, valid one cycle after imem_req
//   redirect        one-cycle pulse: flush and restart at redirect_target
//   redirect_target new PC
//   out_valid       queue head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction
//   out_pc          PC of head instruction
//   out_pc_plus4    out_pc + 4 (link value), modulo 2^ADDR_W
//   fq_count        occupied queue entries
//   misalign_err    one-cycle pulse after a redirect with target[1:0] != 0
// ADDR_W must lie in 4..32.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 4,
  localparam int               CNT_W    = $clog2(FQ_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4,
  output logic [CNT_W-1:0]   fq_count,
  output logic               misalign_err
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_q_reg;      // address of the read currently in flight
  logic              req_q_reg;     // a ROM return arrives this cycle
  logic              misalign_reg;

  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic [CNT_W:0] credit_used;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign out_valid = rst & ~redirect & ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Entries already held plus the one in flight, less the one leaving now.
  // Issuing only while this is below FQ_DEPTH means a return always finds room,
  // and counting the pop keeps 1 instr/cycle flowing even at FQ_DEPTH=2.
  assign credit_used = {1'b0, fq_count}
                     + {{CNT_W{1'b0}}, req_q_reg}
                     - {{CNT_W{1'b0}}, pop};
  assign imem_req  = rst & ~redirect & (credit_used < (CNT_W+1)'(FQ_DEPTH));
  assign imem_addr = pc_reg;

  // A return coinciding with a redirect belongs to the abandoned path.
  assign push             = rst & req_q_reg & ~redirect;
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = MAX_ADDR_W'(pc_q_reg);

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fq_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      req_q_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= redirect & (|redirect_target[1:0]);
      if (redirect) begin
        pc_reg    <= {redirect_target[ADDR_W-1:2], 2'b00};
        req_q_reg <= 1'b0;
      end else if (imem_req) begin
        pc_reg    <= pc_reg + ADDR_W'(4);
        pc_q_reg  <= pc_reg;
        req_q_reg <= 1'b1;
      end else begin
        req_q_reg <= 1'b0;
      end
    end
  end

  // Bubbles show up as NOP so a careless consumer decodes something harmless.
  assign out_instr    = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign out_pc       = ADDR_W'(head_entry.pc);
  assign out_pc_plus4 = out_pc + ADDR_W'(4);
  assign misalign_err = misalign_reg;

endmodule
